rx_write_sequencer: RTL



---
 rtl/rx_write_sequencer_pkg.sv | 24 ++
 rtl/rx_write_sequencer_if.sv | 61 ++++++
 rtl/rx_write_sequencer_psn_table.sv | 27 ++
 rtl/rx_write_sequencer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/rx_write_sequencer_pkg.sv
// Shared encodings for the RDMA WRITE receive sequencer: FSM states, ack status codes, opcodes.
package rdma_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_CMD   = 3'd2,
        ST_DATA  = 3'd3,
        ST_DROP  = 3'd4,
        ST_ACK   = 3'd5
    } state_e;

    localparam logic [1:0] ACK_OK      = 2'b00;
    localparam logic [1:0] ACK_PSN_ERR = 2'b01;
    localparam logic [1:0] ACK_INVALID = 2'b10;
    localparam logic [1:0] ACK_LEN_ERR = 2'b11;

    localparam logic [7:0] OPC_RDMA_WRITE_ONLY = 8'h0A;

    function automatic logic [2:0] popcount4(input logic [3:0] keep);
        return {2'b00, keep[0]} + {2'b00, keep[1]} + {2'b00, keep[2]} + {2'b00, keep[3]};
    endfunction

endpackage

// File: rtl/rx_write_sequencer_if.sv
// Header, payload-in, payload-out, DMA command and ack signals of the write sequencer.
interface rx_write_sequencer_if;
    logic        hdr_valid;
    logic [7:0]  hdr_opcode;
    logic [23:0] hdr_psn;
    logic [23:0] hdr_dest_qp;
    logic [63:0] hdr_remote_addr;
    logic [31:0] hdr_length;

    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;

    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    logic [63:0] cmd_addr;
    logic [31:0] cmd_len;
    logic        cmd_valid;
    logic        cmd_ready;

    logic        ack_valid;
    logic        ack_ready;
    logic [23:0] ack_qp;
    logic [23:0] ack_psn;
    logic [1:0]  ack_status;

    logic        err_hdr_overrun;
    logic        busy;

    modport slave (
        input  hdr_valid, hdr_opcode, hdr_psn, hdr_dest_qp, hdr_remote_addr, hdr_length,
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready,
        output cmd_addr, cmd_len, cmd_valid,
        input  cmd_ready,
        output ack_valid, ack_qp, ack_psn, ack_status,
        input  ack_ready,
        output err_hdr_overrun, busy
    );

    modport master (
        output hdr_valid, hdr_opcode, hdr_psn, hdr_dest_qp, hdr_remote_addr, hdr_length,
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready,
        input  cmd_addr, cmd_len, cmd_valid,
        output cmd_ready,
        input  ack_valid, ack_qp, ack_psn, ack_status,
        output ack_ready,
        input  err_hdr_overrun, busy
    );
endinterface

// File: rtl/rx_write_sequencer_psn_table.sv
// Per-queue-pair expected PSN store: combinational read, +1 (mod 2^24) increment port.
module rx_psn_table #(
    parameter  int NUM_QP = 4,
    localparam int QW     = (NUM_QP > 1) ? $clog2(NUM_QP) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [QW-1:0] rd_qp_i,
    output logic [23:0]   rd_psn_o,
    input  logic          inc_en_i,
    input  logic [QW-1:0] inc_qp_i
);
    logic [23:0] psn_q [NUM_QP];

    always_comb begin
        rd_psn_o = '0;
        if (int'(rd_qp_i) < NUM_QP) rd_psn_o = psn_q[rd_qp_i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_QP; i++) psn_q[i] <= '0;
        end else if (inc_en_i && (int'(inc_qp_i) < NUM_QP)) begin
            psn_q[inc_qp_i] <= psn_q[inc_qp_i] + 24'd1;
        end
    end
endmodule

// File: rtl/rx_write_sequencer.sv
// RDMA WRITE ONLY receive sequencer: validates header, issues DMA command, forwards or drops payload, acks.
module rx_write_sequencer
    import rdma_rx_pkg::*;
#(
    parameter int         NUM_QP    = 4,
    parameter int         MAX_LEN   = 4096,
    parameter logic [7:0] OPC_WRITE = OPC_RDMA_WRITE_ONLY
) (
    input  logic                 aclk,
    input  logic                 areset,
    rx_write_sequencer_if.slave  bus
);
    localparam int QW = (NUM_QP > 1) ? $clog2(NUM_QP) : 1;

    state_e      state_q;
    logic [7:0]  opcode_q;
    logic [23:0] psn_q;
    logic [23:0] qp_q;
    logic [63:0] addr_q;
    logic [31:0] len_q;
    logic [31:0] byte_cnt_q;
    logic [31:0] byte_cnt_d;
    logic [1:0]  status_q;
    logic        cmd_valid_q;
    logic        ack_valid_q;
    logic        err_q;

    logic [23:0] exp_psn;
    logic        psn_inc;
    logic        s_hs;
    logic        req_bad;

    rx_psn_table #(.NUM_QP(NUM_QP)) u_psn (
        .clk      (aclk),
        .rst      (areset),
        .rd_qp_i  (qp_q[QW-1:0]),
        .rd_psn_o (exp_psn),
        .inc_en_i (psn_inc),
        .inc_qp_i (qp_q[QW-1:0])
    );

    assign s_hs       = bus.s_axis_tvalid && bus.s_axis_tready;
    assign byte_cnt_d = byte_cnt_q + {29'd0, popcount4(bus.s_axis_tkeep)};
    assign req_bad    = (opcode_q != OPC_WRITE) || (qp_q >= 24'(NUM_QP)) ||
                        (len_q == 32'd0) || (len_q > 32'(MAX_LEN));
    assign psn_inc    = (state_q == ST_ACK) && ack_valid_q && bus.ack_ready && (status_q == ACK_OK);

    // Payload path is a pure wire in DATA; DROP sinks everything, all other states stall the source.
    always_comb begin
        bus.s_axis_tready = 1'b0;
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tdata  = '0;
        bus.m_axis_tkeep  = '0;
        bus.m_axis_tlast  = 1'b0;
        if (state_q == ST_DATA) begin
            bus.m_axis_tvalid = bus.s_axis_tvalid;
            bus.m_axis_tdata  = bus.s_axis_tdata;
            bus.m_axis_tkeep  = bus.s_axis_tkeep;
            bus.m_axis_tlast  = bus.s_axis_tlast;
            bus.s_axis_tready = bus.m_axis_tready;
        end else if (state_q == ST_DROP) begin
            bus.s_axis_tready = 1'b1;
        end
    end

    assign bus.cmd_valid       = cmd_valid_q;
    assign bus.cmd_addr        = addr_q;
    assign bus.cmd_len         = len_q;
    assign bus.ack_valid       = ack_valid_q;
    assign bus.ack_qp          = qp_q;
    assign bus.ack_psn         = psn_q;
    assign bus.ack_status      = status_q;
    assign bus.err_hdr_overrun = err_q;
    assign bus.busy            = (state_q != ST_IDLE);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            opcode_q    <= '0;
            psn_q       <= '0;
            qp_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            status_q    <= ACK_OK;
            cmd_valid_q <= 1'b0;
            ack_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (bus.hdr_valid && (state_q != ST_IDLE)) err_q <= 1'b1;
            case (state_q)
                ST_IDLE: if (bus.hdr_valid) begin
                    opcode_q   <= bus.hdr_opcode;
                    psn_q      <= bus.hdr_psn;
                    qp_q       <= bus.hdr_dest_qp;
                    addr_q     <= bus.hdr_remote_addr;
                    len_q      <= bus.hdr_length;
                    byte_cnt_q <= '0;
                    state_q    <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (req_bad) begin
                        status_q <= ACK_INVALID;
                        state_q  <= ST_DROP;
                    end else if (psn_q != exp_psn) begin
                        status_q <= ACK_PSN_ERR;
                        state_q  <= ST_DROP;
                    end else begin
                        cmd_valid_q <= 1'b1;
                        state_q     <= ST_CMD;
                    end
                end
                // cmd_valid_q is set on entry, so a handshake here never completes in zero cycles.
                ST_CMD: if (cmd_valid_q && bus.cmd_ready) begin
                    cmd_valid_q <= 1'b0;
                    state_q     <= ST_DATA;
                end
                ST_DATA: if (s_hs) begin
                    byte_cnt_q <= byte_cnt_d;
                    if (bus.s_axis_tlast) begin
                        status_q    <= (byte_cnt_d == len_q) ? ACK_OK : ACK_LEN_ERR;
                        ack_valid_q <= 1'b1;
                        state_q     <= ST_ACK;
                    end
                end
                ST_DROP: if (s_hs && bus.s_axis_tlast) begin
                    ack_valid_q <= 1'b1;
                    state_q     <= ST_ACK;
                end
                ST_ACK: if (ack_valid_q && bus.ack_ready) begin
                    ack_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule
